// File: rtl/conv_encoder_framer.sv
// Rate-1/2 convolutional encoder that packs one DATA_W-bit word into a 2*DATA_W-bit frame.
// Per-frame or continuous encoder state, explicit flush, output back-pressure and a frame counter.
module conv_encoder_framer #(
  parameter int unsigned    DATA_W = 8,
  parameter int unsigned    K      = 3,
  parameter logic [K-1:0]   G0     = 3'b111,
  parameter logic [K-1:0]   G1     = 3'b101,
  parameter int unsigned    CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dvalid_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  mode_i,
  input  logic                  flush_i,
  output logic                  ready_o,
  output logic [2*DATA_W-1:0]   data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      frame_cnt_o
);

  localparam int unsigned ACC_W = 2 * DATA_W;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state_reg;
  logic [K-2:0]      sr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;

  logic              in_bit;
  logic [K-1:0]      window;
  logic [1:0]        sym;
  logic [ACC_W-1:0]  acc_next;

  // Newest previous bit sits at sr_reg[K-2], right below the incoming bit.
  assign in_bit   = data_reg[DATA_W-1];
  assign window   = {in_bit, sr_reg};
  assign sym      = {^(window & G0), ^(window & G1)};
  assign acc_next = (acc_reg << 2) | ACC_W'(sym);

  assign ready_o  = (state_reg == IDLE);
  assign busy_o   = ~ready_o;
  assign valid_o  = (state_reg == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      sr_reg      <= '0;
      data_reg    <= '0;
      acc_reg     <= '0;
      bit_cnt_reg <= '0;
      data_o      <= '0;
      frame_cnt_o <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (dvalid_i) begin
            data_reg    <= data_i;
            bit_cnt_reg <= BIT_W'(DATA_W - 1);
            state_reg   <= SHIFT;
            if (!mode_i || flush_i) begin
              sr_reg <= '0;
            end
          end else if (flush_i) begin
            sr_reg <= '0;
          end
        end
        SHIFT: begin
          sr_reg   <= window[K-1:1];
          data_reg <= data_reg << 1;
          acc_reg  <= acc_next;
          if (bit_cnt_reg == '0) begin
            data_o    <= acc_next;
            state_reg <= DONE;
          end else begin
            bit_cnt_reg <= bit_cnt_reg - 1'b1;
          end
        end
        DONE: begin
          if (ready_i) begin
            frame_cnt_o <= frame_cnt_o + 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Directed bench for conv_encoder_framer: hand-computed (7,5) K=3 frames, modes, flush,
// back-pressure, mid-frame reset and counter wrap on a second CNT_W=2 instance.
module tb_conv_encoder_framer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, dvalid, mode, flush, rdy_in;
  logic [7:0]  din;
  logic [15:0] dout;
  logic        valid, rdy_out, busy;
  logic [15:0] cnt;

  logic        rst2, dvalid2, mode2, flush2, rdy_in2;
  logic [7:0]  din2;
  logic [15:0] dout2;
  logic        valid2, rdy_out2, busy2;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  conv_encoder_framer dut (
    .clk(clk), .rst(rst), .dvalid_i(dvalid), .data_i(din), .mode_i(mode),
    .flush_i(flush), .ready_o(rdy_out), .data_o(dout), .valid_o(valid),
    .ready_i(rdy_in), .busy_o(busy), .frame_cnt_o(cnt)
  );

  conv_encoder_framer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .dvalid_i(dvalid2), .data_i(din2), .mode_i(mode2),
    .flush_i(flush2), .ready_o(rdy_out2), .data_o(dout2), .valid_o(valid2),
    .ready_i(rdy_in2), .busy_o(busy2), .frame_cnt_o(cnt2)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offers one word with ready_i=1 and returns the frame plus its latency from the accept edge.
  task automatic send_frame(input logic [7:0] d, input logic m, input logic f,
                            output logic [15:0] got, output int lat, output logic rdy_at_valid);
    got = '0;
    lat = -1;
    rdy_at_valid = 1'b1;
    @(negedge clk);
    dvalid = 1'b1; din = d; mode = m; flush = f;
    @(posedge clk); #1;
    dvalid = 1'b0; flush = 1'b0; mode = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (valid) begin
        got = dout; lat = i; rdy_at_valid = rdy_out;
        break;
      end
    end
    for (int i = 0; i < 40 && !rdy_out; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", rdy_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", dout); end
    checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] got; int lat; logic rv;
    send_frame(8'h55, 1'b0, 1'b0, got, lat, rv);
    checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency got %0d exp 8", lat); end
    checks++; if (got !== 16'h3888) begin errors++; $display("FAIL basic_data got %h exp 3888", got); end
    checks++; if (rv !== 1'b0) begin errors++; $display("FAIL basic_ready_during_valid got %b exp 0", rv); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_one_cycle got %b exp 0", valid); end
    checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL basic_cnt got %0d exp 1", cnt); end
    checks++; if (dut.sr_reg !== 2'b10) begin errors++; $display("FAIL basic_sr got %b exp 10", dut.sr_reg); end
    checks++; if (dout !== 16'h3888) begin errors++; $display("FAIL basic_data_hold got %h exp 3888", dout); end
  endtask

  task automatic test_per_frame();
    logic [15:0] got; int lat; logic rv;
    send_frame(8'hFF, 1'b0, 1'b0, got, lat, rv);
    checks++; if (got !== 16'hDAAA) begin errors++; $display("FAIL perframe_ff got %h exp DAAA", got); end
    send_frame(8'h55, 1'b0, 1'b0, got, lat, rv);
    checks++; if (got !== 16'h3888) begin errors++; $display("FAIL perframe_55 got %h exp 3888", got); end
    checks++; if (cnt !== 16'd3) begin errors++; $display("FAIL perframe_cnt got %0d exp 3", cnt); end
  endtask

  task automatic test_continuous();
    logic [15:0] got; int lat; logic rv;
    do_reset();
    send_frame(8'h55, 1'b1, 1'b0, got, lat, rv);
    checks++; if (got !== 16'h3888) begin errors++; $display("FAIL cont_first got %h exp 3888", got); end
    send_frame(8'h55, 1'b1, 1'b0, got, lat, rv);
    checks++; if (got !== 16'h8888) begin errors++; $display("FAIL cont_second got %h exp 8888", got); end
  endtask

  task automatic test_flush();
    logic [15:0] got; int lat; logic rv;
    do_reset();
    send_frame(8'h55, 1'b1, 1'b0, got, lat, rv);
    checks++; if (got !== 16'h3888) begin errors++; $display("FAIL flush_pre got %h exp 3888", got); end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL flush_stays_idle got %b exp 1", rdy_out); end
    checks++; if (dut.sr_reg !== 2'b00) begin errors++; $display("FAIL flush_sr got %b exp 00", dut.sr_reg); end
    send_frame(8'h55, 1'b1, 1'b0, got, lat, rv);
    checks++; if (got !== 16'h3888) begin errors++; $display("FAIL flush_idle got %h exp 3888", got); end
    send_frame(8'h55, 1'b1, 1'b1, got, lat, rv);
    checks++; if (got !== 16'h3888) begin errors++; $display("FAIL flush_with_dvalid got %h exp 3888", got); end
  endtask

  task automatic test_back_pressure();
    int lat;
    do_reset();
    rdy_in = 1'b0;
    @(negedge clk);
    dvalid = 1'b1; din = 8'h55; mode = 1'b0;
    @(posedge clk); #1;
    din = 8'hFF;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (valid) begin lat = i; break; end
    end
    checks++; if (lat != 8) begin errors++; $display("FAIL bp_latency got %0d exp 8", lat); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold cyc %0d got %b exp 1", i, valid); end
      checks++; if (dout !== 16'h3888) begin errors++; $display("FAIL bp_data_hold cyc %0d got %h exp 3888", i, dout); end
      checks++; if (rdy_out !== 1'b0) begin errors++; $display("FAIL bp_ready cyc %0d got %b exp 0", i, rdy_out); end
    end
    checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL bp_cnt_stall got %0d exp 0", cnt); end
    @(negedge clk);
    rdy_in = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL bp_idle_after_hs got %b exp 1", rdy_out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after_hs got %b exp 0", valid); end
    checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL bp_cnt_after_hs got %0d exp 1", cnt); end
    @(posedge clk); #1;
    checks++; if (rdy_out !== 1'b0) begin errors++; $display("FAIL bp_second_accept got %b exp 0", rdy_out); end
    dvalid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (valid) begin lat = i; break; end
    end
    checks++; if (lat != 8) begin errors++; $display("FAIL bp_second_latency got %0d exp 8", lat); end
    checks++; if (dout !== 16'hDAAA) begin errors++; $display("FAIL bp_second_data got %h exp DAAA", dout); end
    @(posedge clk); #1;
    checks++; if (cnt !== 16'd2) begin errors++; $display("FAIL bp_cnt_final got %0d exp 2", cnt); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    logic [15:0] got; int lat; logic rv;
    @(negedge clk);
    dvalid = 1'b1; din = 8'h55; mode = 1'b0;
    @(posedge clk); #1;
    dvalid = 1'b0;
    checks++; if (rdy_out !== 1'b0) begin errors++; $display("FAIL mid_accept got %b exp 0", rdy_out); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", rdy_out); end
    checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt got %0d exp 0", cnt); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_valid got %b exp 0", seen); end
    // Now abort a frame parked in DONE.
    send_frame(8'hFF, 1'b0, 1'b0, got, lat, rv);
    rdy_in = 1'b0;
    @(negedge clk);
    dvalid = 1'b1; din = 8'h55;
    @(posedge clk); #1;
    dvalid = 1'b0;
    for (int i = 0; i < 40 && !valid; i++) begin
      @(posedge clk); #1;
    end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL done_reach got %b exp 1", valid); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL done_abort_valid got %b exp 0", valid); end
    checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL done_abort_cnt got %0d exp 0", cnt); end
    @(negedge clk);
    rst = 1'b0;
    rdy_in = 1'b1;
  endtask

  task automatic test_wrap();
    logic [1:0] exp2;
    int waited;
    @(negedge clk);
    rst2 = 1'b0;
    dvalid2 = 1'b1; din2 = 8'h55;
    for (int f = 1; f <= 4; f++) begin
      waited = 0;
      @(posedge clk); #1;
      while (!valid2 && waited < 40) begin
        @(posedge clk); #1;
        waited++;
      end
      checks++; if (valid2 !== 1'b1) begin errors++; $display("FAIL wrap_valid frame %0d got %b exp 1", f, valid2); end
      @(posedge clk); #1;
      exp2 = 2'(f);
      checks++; if (cnt2 !== exp2) begin errors++; $display("FAIL wrap_cnt frame %0d got %0d exp %0d", f, cnt2, exp2); end
    end
    dvalid2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dvalid = 1'b0; mode = 1'b0; flush = 1'b0; rdy_in = 1'b1; din = 8'h00;
    rst2 = 1'b1; dvalid2 = 1'b0; mode2 = 1'b0; flush2 = 1'b0; rdy_in2 = 1'b1; din2 = 8'h00;
    test_reset();
    test_basic();
    test_per_frame();
    test_continuous();
    test_flush();
    test_back_pressure();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
